request_collector: RTL and testbench
====================================

// Module: request_collector
// PURPOSE
//  Upstream front end of the round-robin dynamic-priority arbiter. Takes N raw
//  push-button inputs and synchronises and debounces each one.
//  Turns each debounced press into a sticky request with a priority snapshot
//  taken from switch inputs. Drives req/prt into the arbiter.
//  Clears a request when the arbiter's grant for that requester is consumed.
// PARAMETERS
//  N          4               number of requesters
//  LN         $clog2(N)       width of grant index and priority field
//  DB_CYCLES  65535           consecutive stable cycles needed to accept a level change (>=2)
// PORTS
//  clk        in   1          system clock
//  rst        in   1          reset
//  btn        in   N          raw asynchronous buttons, active-high
//  prt_sw     in   N*LN       priority switches; requester i = prt_sw[i*LN +: LN]
//  grant      in   LN         arbiter grant index
//  valid      in   1          arbiter grant valid
//  grant_stb  in   1          1-cycle strobe: grant/valid are being consumed this cycle
//  ovr_clr    in   1          clears all overrun flags and bad_ack
//  req        out  N          pending requests to arbiter
//  prt        out  LN x N     unpacked [LN-1:0] prt [N-1:0]; priority snapshot per requester
//  overrun    out  N          sticky: press arrived while request already pending
//  bad_ack    out  1          sticky: strobe consumed a grant whose request was not pending
// BEHAVIOUR
//  Clock/reset: one clock, clk. rst is synchronous, active-high; all state
//   returns to 0: sync flops, debounce counters, debounced levels, req, prt,
//   overrun, bad_ack.
//  Sync: per bit, a 2-flop synchroniser gives s2[i].
//  Debounce: per bit, a level d[i] and a counter c[i] of width $clog2(DB_CYCLES).
//   - If s2[i]==d[i]: c[i]<=0.
//   - Otherwise, if c[i]==DB_CYCLES-1: d[i]<=s2[i] and c[i]<=0.
//   - Otherwise: c[i]<=c[i]+1.
//   - A glitch shorter than DB_CYCLES cycles never changes d[i].
//  Press: press[i] = (a 0->1 update of d[i] at this edge). It is one cycle
//   wide and is derived from the next-state value, so req rises on the same
//   edge as d.
//  Timing: first edge where sync flop 1 captures btn=1 is edge k. Then d[i]
//   and req[i] go high at edge k+1+DB_CYCLES. Release has no effect on req.
//  Ack: ack = grant_stb & valid. It targets requester g=grant.
//   - If req[g]==1: req[g]<=0; prt[g] holds its value.
//   - If req[g]==0: bad_ack<=1; req is unchanged.
//   - grant_stb with valid=0 is ignored.
//  Set: on press[i], req[i]<=1 and prt[i]<=prt_sw[i*LN +: LN]. prt[i] is
//   frozen while req[i]==1; switch changes are ignored until the next accepted press.
//  Overrun: press[i] while req[i]==1 and not acked this cycle -> overrun[i]<=1.
//   The existing request and its prt snapshot are kept.
//  Simultaneous press[i] and ack of i:
//   - The set wins: req[i] stays 1.
//   - prt[i] is re-snapshotted.
//   - No overrun is raised.
//  Simultaneous presses on several channels are all accepted in the same cycle.
//  ovr_clr: clears overrun and bad_ack. If a new overrun or bad_ack event
//   occurs in the same cycle, that event wins (flag stays/sets to 1).
//  Reset mid-operation: everything is cleared. A button still held after rst
//   releases yields a fresh press DB_CYCLES+2 cycles later.
//  Latency: all outputs are registered. No combinational path from any input
//   to any output.
//  Width: grant values >= N are ignored, with no flag.
// TESTING (N=4, LN=2, DB_CYCLES=4)
//  Debounce: btn[1] high from edge 0, prt_sw[3:2]=2'd3 -> req=4'b0010 after
//   edge 5, prt[1]=3. A 3-cycle btn[0] glitch leaves req[0]=0.
//  Ack: req=4'b0010; grant=1, valid=1, grant_stb=1 for one cycle -> req=0
//   next cycle, bad_ack=0.
//  Overrun: req[2]=1; release then re-press btn[2] (debounced) -> overrun=4'b0100,
//   req[2] stays 1, prt[2] unchanged. Pulse ovr_clr -> overrun=0.
//  Collision: press[3] on the same edge as ack of 3 -> req[3]=1, prt[3]=new
//   switch value, overrun[3]=0.
//  Bad ack: req=0, grant=2, valid=1, grant_stb=1 -> bad_ack=1, req=0.
//   valid=0 with strobe -> no change.
//  Reset: assert rst mid-debounce with req=4'b1001 -> next cycle all outputs 0.
//   Held btn[0] -> req[0]=1 six cycles after rst deasserts.

Source files
------------

// File: rtl/request_collector.sv
// Front end for the round-robin arbiter: synchronises and debounces push buttons,
// turns presses into sticky requests with a priority snapshot, and retires them on grant.
module request_collector #(
    parameter int N         = 4,
    parameter int LN        = $clog2(N),
    parameter int DB_CYCLES = 65535
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N-1:0]      btn,
    input  logic [N*LN-1:0]   prt_sw,
    input  logic [LN-1:0]     grant,
    input  logic              valid,
    input  logic              grant_stb,
    input  logic              ovr_clr,
    output logic [N-1:0]      req,
    output logic [LN-1:0]     prt [N-1:0],
    output logic [N-1:0]      overrun,
    output logic              bad_ack
);

    localparam int            CW     = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_TC = CW'(DB_CYCLES - 1);

    logic [N-1:0]  s1;
    logic [N-1:0]  s2;
    logic [N-1:0]  d;
    logic [N-1:0]  d_nxt;
    logic [CW-1:0] cnt     [N-1:0];
    logic [CW-1:0] cnt_nxt [N-1:0];

    logic          ack;
    logic [N-1:0]  press;
    logic [N-1:0]  grant_hit;
    logic [N-1:0]  req_nxt;
    logic [N-1:0]  snap;
    logic [N-1:0]  ovr_evt;
    logic          bad_evt;

    // Counter runs only while the synchronised input disagrees with the accepted level.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            d_nxt[i]   = d[i];
            cnt_nxt[i] = '0;
            if (s2[i] != d[i]) begin
                if (cnt[i] == CNT_TC) begin
                    d_nxt[i] = s2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    assign press = d_nxt & ~d;
    assign ack   = grant_stb & valid;

    always_comb begin
        for (int i = 0; i < N; i++) begin
            grant_hit[i] = ack && (grant == LN'(i));
        end
    end

    // A press coinciding with the ack of the same requester re-arms it with a fresh snapshot.
    assign req_nxt = press | (req & ~grant_hit);
    assign snap    = press & (~req | grant_hit);
    assign ovr_evt = press & req & ~grant_hit;
    assign bad_evt = (|grant_hit) & ~(|(grant_hit & req));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1      <= '0;
            s2      <= '0;
            d       <= '0;
            req     <= '0;
            overrun <= '0;
            bad_ack <= 1'b0;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= '0;
                prt[i] <= '0;
            end
        end else begin
            s1      <= btn;
            s2      <= s1;
            d       <= d_nxt;
            req     <= req_nxt;
            overrun <= (ovr_clr ? '0 : overrun) | ovr_evt;
            bad_ack <= (bad_ack & ~ovr_clr) | bad_evt;
            for (int i = 0; i < N; i++) begin
                cnt[i] <= cnt_nxt[i];
                if (snap[i]) begin
                    prt[i] <= prt_sw[i*LN +: LN];
                end
            end
        end
    end

endmodule

// File: tb/tb_request_collector.sv
// Bench for request_collector: directed vector table followed by random traffic
// checked against a window-based behavioural model.
module tb_request_collector;

    localparam int N  = 4;
    localparam int LN = 2;
    localparam int DB = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  btn;
    logic [N*LN-1:0] prt_sw;
    logic [LN-1:0] grant;
    logic          valid;
    logic          grant_stb;
    logic          ovr_clr;
    logic [N-1:0]  req;
    logic [LN-1:0] prt [N-1:0];
    logic [N-1:0]  overrun;
    logic          bad_ack;
    logic [7:0]    prt_pk;

    request_collector #(.N(N), .LN(LN), .DB_CYCLES(DB)) dut (
        .clk(clk), .rst(rst), .btn(btn), .prt_sw(prt_sw), .grant(grant),
        .valid(valid), .grant_stb(grant_stb), .ovr_clr(ovr_clr),
        .req(req), .prt(prt), .overrun(overrun), .bad_ack(bad_ack)
    );

    always #5 clk = ~clk;

    assign prt_pk = {prt[3], prt[2], prt[1], prt[0]};

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model: a level is accepted once the last DB synchroniser outputs all disagree with it.
    logic [N-1:0]  m_d;
    logic [N-1:0]  m_req;
    logic [LN-1:0] m_prt [N];
    logic [N-1:0]  m_ovr;
    logic          m_bad;
    logic [N-1:0]  hist [$];

    function automatic logic [7:0] m_prt_pk();
        return {m_prt[3], m_prt[2], m_prt[1], m_prt[0]};
    endfunction

    task automatic model_step();
        logic          ack_ok;
        logic          all_mis;
        logic [N-1:0]  pr;
        int            g;
        if (rst) begin
            m_d   = '0;
            m_req = '0;
            m_ovr = '0;
            m_bad = 1'b0;
            for (int i = 0; i < N; i++) m_prt[i] = '0;
            hist = {};
            for (int k = 0; k < DB + 2; k++) hist.push_back('0);
            return;
        end
        for (int i = 0; i < N; i++) begin
            all_mis = 1'b1;
            for (int j = 0; j < DB; j++)
                if (hist[hist.size() - 2 - j][i] == m_d[i]) all_mis = 1'b0;
            pr[i] = all_mis && !m_d[i];
            if (all_mis) m_d[i] = ~m_d[i];
        end
        g      = int'(grant);
        ack_ok = grant_stb && valid && (g < N);
        if (ovr_clr) begin
            m_ovr = '0;
            m_bad = 1'b0;
        end
        if (ack_ok && !m_req[g]) m_bad = 1'b1;
        for (int i = 0; i < N; i++) begin
            logic acked;
            acked = ack_ok && (g == i);
            if (pr[i]) begin
                if (m_req[i] && !acked) begin
                    m_ovr[i] = 1'b1;
                end else begin
                    m_req[i] = 1'b1;
                    m_prt[i] = prt_sw[i*LN +: LN];
                end
            end else if (acked) begin
                m_req[i] = 1'b0;
            end
        end
        hist.push_back(btn);
        if (hist.size() > DB + 2) void'(hist.pop_front());
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at time %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        check("model_req",     32'(req),     32'(m_req));
        check("model_prt",     32'(prt_pk),  32'(m_prt_pk()));
        check("model_overrun", 32'(overrun), 32'(m_ovr));
        check("model_bad_ack", 32'(bad_ack), 32'(m_bad));
    endtask

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic [7:0] sw;
        logic [1:0] grant;
        logic       valid;
        logic       stb;
        logic       clr;
        int         cyc;
        logic [3:0] e_req;
        logic [7:0] e_prt;
        logic [3:0] e_ovr;
        logic       e_bad;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic [3:0] b, input logic [7:0] s,
                                input logic [1:0] g, input logic v, input logic st,
                                input logic c, input int n, input logic [3:0] er,
                                input logic [7:0] ep, input logic [3:0] eo, input logic eb);
        vec_t t;
        t.rst = r; t.btn = b; t.sw = s; t.grant = g; t.valid = v; t.stb = st;
        t.clr = c; t.cyc = n; t.e_req = er; t.e_prt = ep; t.e_ovr = eo; t.e_bad = eb;
        return t;
    endfunction

    vec_t tbl [23];

    initial begin
        //            rst btn   sw     gnt v  stb clr cyc req    prt    ovr    bad
        tbl[0]  = mk(1, 4'h0, 8'h00, 0, 0, 0, 0, 2, 4'h0, 8'h00, 4'h0, 0);
        tbl[1]  = mk(0, 4'h2, 8'h0C, 0, 0, 0, 0, 5, 4'h0, 8'h00, 4'h0, 0);
        tbl[2]  = mk(0, 4'h2, 8'h0C, 0, 0, 0, 0, 1, 4'h2, 8'h0C, 4'h0, 0);
        tbl[3]  = mk(0, 4'h3, 8'h0C, 0, 0, 0, 0, 3, 4'h2, 8'h0C, 4'h0, 0);
        tbl[4]  = mk(0, 4'h2, 8'h0C, 0, 0, 0, 0, 6, 4'h2, 8'h0C, 4'h0, 0);
        tbl[5]  = mk(0, 4'h2, 8'h0C, 1, 1, 1, 0, 1, 4'h0, 8'h0C, 4'h0, 0);
        tbl[6]  = mk(0, 4'h2, 8'h0C, 2, 1, 1, 0, 1, 4'h0, 8'h0C, 4'h0, 1);
        tbl[7]  = mk(0, 4'h2, 8'h0C, 0, 0, 0, 1, 1, 4'h0, 8'h0C, 4'h0, 0);
        tbl[8]  = mk(0, 4'h2, 8'h0C, 2, 0, 1, 0, 1, 4'h0, 8'h0C, 4'h0, 0);
        tbl[9]  = mk(0, 4'h6, 8'h1C, 0, 0, 0, 0, 6, 4'h4, 8'h1C, 4'h0, 0);
        tbl[10] = mk(0, 4'h2, 8'h2C, 0, 0, 0, 0, 6, 4'h4, 8'h1C, 4'h0, 0);
        tbl[11] = mk(0, 4'h6, 8'h2C, 0, 0, 0, 0, 6, 4'h4, 8'h1C, 4'h4, 0);
        tbl[12] = mk(0, 4'h6, 8'h2C, 0, 0, 0, 1, 1, 4'h4, 8'h1C, 4'h0, 0);
        tbl[13] = mk(0, 4'hE, 8'h6C, 0, 0, 0, 0, 6, 4'hC, 8'h5C, 4'h0, 0);
        tbl[14] = mk(0, 4'h6, 8'h6C, 0, 0, 0, 0, 6, 4'hC, 8'h5C, 4'h0, 0);
        tbl[15] = mk(0, 4'hE, 8'hAC, 0, 0, 0, 0, 5, 4'hC, 8'h5C, 4'h0, 0);
        tbl[16] = mk(0, 4'hE, 8'hAC, 3, 1, 1, 0, 1, 4'hC, 8'h9C, 4'h0, 0);
        tbl[17] = mk(1, 4'h0, 8'h00, 0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0, 0);
        tbl[18] = mk(0, 4'h9, 8'hC2, 0, 0, 0, 0, 6, 4'h9, 8'hC2, 4'h0, 0);
        tbl[19] = mk(0, 4'hB, 8'hC2, 0, 0, 0, 0, 2, 4'h9, 8'hC2, 4'h0, 0);
        tbl[20] = mk(1, 4'hB, 8'hC2, 0, 0, 0, 0, 1, 4'h0, 8'h00, 4'h0, 0);
        tbl[21] = mk(0, 4'h1, 8'hC2, 0, 0, 0, 0, 5, 4'h0, 8'h00, 4'h0, 0);
        tbl[22] = mk(0, 4'h1, 8'hC2, 0, 0, 0, 0, 1, 4'h1, 8'h02, 4'h0, 0);

        rst = 1'b1; btn = '0; prt_sw = '0; grant = '0;
        valid = 1'b0; grant_stb = 1'b0; ovr_clr = 1'b0;
        for (int k = 0; k < DB + 2; k++) hist.push_back('0);
        #1;

        for (int s = 0; s < 23; s++) begin
            rst = tbl[s].rst; btn = tbl[s].btn; prt_sw = tbl[s].sw;
            grant = tbl[s].grant; valid = tbl[s].valid;
            grant_stb = tbl[s].stb; ovr_clr = tbl[s].clr;
            for (int c = 0; c < tbl[s].cyc; c++) tick();
            check($sformatf("step%0d_req", s),     32'(req),     32'(tbl[s].e_req));
            check($sformatf("step%0d_prt", s),     32'(prt_pk),  32'(tbl[s].e_prt));
            check($sformatf("step%0d_overrun", s), 32'(overrun), 32'(tbl[s].e_ovr));
            check($sformatf("step%0d_bad_ack", s), 32'(bad_ack), 32'(tbl[s].e_bad));
        end

        rst = 1'b1; btn = '0; grant_stb = 1'b0; ovr_clr = 1'b0;
        tick();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 499) == 0);
            for (int i = 0; i < N; i++)
                if ($urandom_range(0, 7) == 0) btn[i] = ~btn[i];
            prt_sw    = 8'($urandom);
            grant     = 2'($urandom);
            valid     = ($urandom_range(0, 3) != 0);
            grant_stb = ($urandom_range(0, 2) == 0);
            ovr_clr   = ($urandom_range(0, 19) == 0);
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
